// File: rtl/seq_tx_pkg.sv
// Shared types and helpers for the serial pattern transmitter: state encoding,
// counter sizing and preamble bit generation.
package seq_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } tx_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // One counter covers the preamble, data and gap phases, so it is sized
    // for the longest of the three.
    function automatic int cnt_width(input int pat_w, input int pre_bits, input int gap_cyc);
        int m;
        m = max3(pat_w, pre_bits, gap_cyc);
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    // Preamble alternates 1,0,1,0,... starting at index 0.
    function automatic logic pre_bit(input logic idx_lsb);
        return ~idx_lsb;
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// PAT_W-bit load/shift register that exposes the next bit to transmit; the
// shift direction follows MSB_FIRST.
module bit_serializer #(
    parameter int PAT_W     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] din,
    output logic             head
);

    logic [PAT_W-1:0] sr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            if (MSB_FIRST != 0) sr <= sr << 1;
            else                sr <= sr >> 1;
        end
    end

    assign head = (MSB_FIRST != 0) ? sr[PAT_W-1] : sr[0];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: preamble, pattern, idle gap, with Mealy outputs.
// Define SEQ_TX_REG_OUT_EN to register dout/dout_valid/done (adds one cycle).
//
// state | meaning
// IDLE  | in_ready=1; a handshake emits preamble bit 0 in the same cycle
// PRE   | remaining preamble bits, count = preamble index
// DATA  | pattern bits from the serializer head, count = data index
// GAP   | quiet cycles before the next accept
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int PAT_W     = 8,
    parameter int PRE_BITS  = 2,
    parameter int GAP_CYC   = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PAT_W-1:0] in_pattern,
    output logic             dout,
    output logic             dout_valid,
    output logic             done
);

    localparam int CNT_W = cnt_width(PAT_W, PRE_BITS, GAP_CYC);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    tx_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             load, shift, head;
    logic             rdy_c, dout_c, dv_c, done_c;

    bit_serializer #(
        .PAT_W     (PAT_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_ser (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (in_pattern),
        .head  (head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        shift     = 1'b0;
        rdy_c     = 1'b0;
        dout_c    = 1'b0;
        dv_c      = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                rdy_c = 1'b1;
                if (in_valid) begin
                    dv_c   = 1'b1;
                    dout_c = 1'b1;
                    load   = 1'b1;
                    if (PRE_BITS > 1) begin
                        state_nxt = PRE;
                        cnt_nxt   = CNT_W'(1);
                    end else begin
                        state_nxt = DATA;
                        cnt_nxt   = '0;
                    end
                end
            end
            PRE: begin
                dv_c   = 1'b1;
                dout_c = pre_bit(cnt[0]);
                if (cnt == PRE_LAST) begin
                    state_nxt = DATA;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                dv_c   = 1'b1;
                dout_c = head;
                shift  = 1'b1;
                if (cnt == DATA_LAST) begin
                    done_c  = 1'b1;
                    cnt_nxt = '0;
                    if (GAP_CYC > 0) state_nxt = GAP;
                    else             state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Mealy outputs follow in_valid, so they are gated to keep them low during reset.
    assign in_ready = rdy_c & reset;

`ifdef SEQ_TX_REG_OUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            dout       <= dout_c;
            dout_valid <= dv_c;
            done       <= done_c;
        end
    end
`else
    assign dout       = dout_c & reset;
    assign dout_valid = dv_c & reset;
    assign done       = done_c & reset;
`endif

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: default, LSB-first and zero-gap instances
// driven with hand-computed bit streams.
module tb_seq_pattern_tx;

`ifdef SEQ_TX_REG_OUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic            clk;
    logic            reset;
    logic [2:0]      vld;
    logic [2:0][7:0] pat;
    logic [2:0]      rdy, dout_w, dv_w, done_w;

    int n_tests = 0;
    int n_fail  = 0;

    // 0: defaults, 1: LSB first, 2: zero gap
    seq_pattern_tx u_dut (
        .clk(clk), .reset(reset), .in_valid(vld[0]), .in_ready(rdy[0]),
        .in_pattern(pat[0]), .dout(dout_w[0]), .dout_valid(dv_w[0]), .done(done_w[0])
    );

    seq_pattern_tx #(.MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .in_valid(vld[1]), .in_ready(rdy[1]),
        .in_pattern(pat[1]), .dout(dout_w[1]), .dout_valid(dv_w[1]), .done(done_w[1])
    );

    seq_pattern_tx #(.GAP_CYC(0)) u_gap0 (
        .clk(clk), .reset(reset), .in_valid(vld[2]), .in_ready(rdy[2]),
        .in_pattern(pat[2]), .dout(dout_w[2]), .dout_valid(dv_w[2]), .done(done_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered just after a rising edge with instance d in IDLE. bits holds the
    // expected serial stream, first bit at bits[n-1]. g is the instance's GAP_CYC.
    task automatic frame(input int d, input int g, input logic [7:0] p0, input logic [7:0] p1,
                         input logic [19:0] bits, input int n, input bit hold, input bit poke,
                         input string tag);
        int k;
        logic exp_dv, exp_d, exp_done, exp_rdy;
        for (int c = 0; c <= n + 1 + LAT; c++) begin
            vld[d] = hold ? (c < n) : (c == 0);
            pat[d] = (c < 10) ? p0 : p1;
            if (poke && c >= 3 && c <= 8) begin
                vld[d] = (c % 2 == 1);
                pat[d] = 8'h3C;
            end
            @(negedge clk);
            k        = c - LAT;
            exp_dv   = (k >= 0) && (k < n);
            exp_d    = exp_dv ? bits[n-1-k] : 1'b0;
            exp_done = exp_dv && (k % 10 == 9);
            exp_rdy  = (c == 0) || (c > n) || (g == 0 && c % 10 == 0);
            check($sformatf("%s dout_valid c%0d", tag, c), dv_w[d], exp_dv);
            check($sformatf("%s dout c%0d", tag, c), dout_w[d], exp_d);
            check($sformatf("%s done c%0d", tag, c), done_w[d], exp_done);
            check($sformatf("%s in_ready c%0d", tag, c), rdy[d], exp_rdy);
            @(posedge clk);
            #1;
        end
        vld[d] = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        vld   = '0;
        pat   = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", rdy[0], 1'b0);
        check("reset dout_valid", dv_w[0], 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("post reset in_ready dflt", rdy[0], 1'b1);
        check("post reset in_ready lsb", rdy[1], 1'b1);
        check("post reset in_ready gap0", rdy[2], 1'b1);
        check("post reset dout_valid", dv_w[0], 1'b0);
        @(posedge clk);
        #1;

        frame(0, 1, 8'hA5, 8'h00, 20'b1010100101, 10, 1'b0, 1'b0, "basic");
        frame(0, 1, 8'hA5, 8'h00, 20'b1010100101, 10, 1'b0, 1'b1, "busy");
        frame(1, 1, 8'h01, 8'h00, 20'b1010000000, 10, 1'b0, 1'b0, "lsb");
        frame(2, 0, 8'hFF, 8'h00, 20'b10111111111000000000, 20, 1'b1, 1'b0, "b2b");

        // Abort an 0xA5 frame at cycle 5 with an asynchronous reset.
        vld[0] = 1'b1;
        pat[0] = 8'hA5;
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort pre dout_valid", dv_w[0], LAT == 0 ? 1'b1 : 1'b1);
        #2;
        reset  = 1'b0;
        vld[0] = 1'b1;
        #1;
        check("abort dout", dout_w[0], 1'b0);
        check("abort dout_valid", dv_w[0], 1'b0);
        check("abort done", done_w[0], 1'b0);
        check("abort in_ready", rdy[0], 1'b0);
        @(negedge clk);
        check("abort hold dout_valid", dv_w[0], 1'b0);
        check("abort hold done", done_w[0], 1'b0);
        check("abort hold in_ready", rdy[0], 1'b0);
        @(posedge clk);
        #1;
        check("abort hold2 done", done_w[0], 1'b0);
        vld[0] = 1'b0;
        reset  = 1'b1;
        #1;
        check("abort release in_ready", rdy[0], 1'b1);
        check("abort release dout_valid", dv_w[0], 1'b0);
        @(posedge clk);
        #1;

        frame(0, 1, 8'h5A, 8'h00, 20'b1001011010, 10, 1'b0, 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
